// File: rtl/pcie_us_cfg_mgmt_arb.sv
// pcie_us_cfg_mgmt_arb
// Round-robin arbiter that shares the UltraScale+ PCIe cfg_mgmt port among
// PORTS requesters. Each accepted request becomes one read or write strobe that
// is held until cfg_mgmt_read_write_done (or a timeout), followed by exactly one
// response pulse to the requester that issued it.
//
// Ports:
//   clk, rst_n                 PCIe user clock, async active-low reset
//   s_req_*                    per-port request (valid/ready handshake, packed fields)
//   s_resp_valid               one-cycle response pulse, one bit per port
//   s_resp_read_data/_error    shared response payload qualified by s_resp_valid
//   cfg_mgmt_*                 hard IP configuration management interface
//   busy                       high while a transaction is outstanding
module pcie_us_cfg_mgmt_arb #(
   parameter int unsigned PORTS   = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PORTS-1:0]    s_req_valid,
   output logic [PORTS-1:0]    s_req_ready,
   input  logic [PORTS-1:0]    s_req_write,
   input  logic [PORTS*10-1:0] s_req_addr,
   input  logic [PORTS*8-1:0]  s_req_function_number,
   input  logic [PORTS*32-1:0] s_req_write_data,
   input  logic [PORTS*4-1:0]  s_req_byte_enable,
   output logic [PORTS-1:0]    s_resp_valid,
   output logic [31:0]         s_resp_read_data,
   output logic                s_resp_error,
   output logic [9:0]          cfg_mgmt_addr,
   output logic [7:0]          cfg_mgmt_function_number,
   output logic                cfg_mgmt_write,
   output logic [31:0]         cfg_mgmt_write_data,
   output logic [3:0]          cfg_mgmt_byte_enable,
   output logic                cfg_mgmt_read,
   input  logic [31:0]         cfg_mgmt_read_data,
   input  logic                cfg_mgmt_read_write_done,
   output logic                busy
);

   localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   grant_idx;
   logic [PW-1:0]   first_idx;
   logic [PW-1:0]   upper_idx;
   logic            first_vld;
   logic            upper_vld;
   logic            grant_vld;
   logic            done_exit;
   logic            timeout_exit;
   logic [CW-1:0]   cnt;
   logic            sel_write;
   logic [9:0]      sel_addr;
   logic [7:0]      sel_fn;
   logic [31:0]     sel_wdata;
   logic [3:0]      sel_be;

   // Round-robin pick: lowest valid port at or above ptr, else lowest valid port overall.
   always_comb begin
      first_vld = 1'b0;
      first_idx = '0;
      upper_vld = 1'b0;
      upper_idx = '0;
      for (int j = PORTS - 1; j >= 0; j--) begin
         if (s_req_valid[j]) begin
            first_vld = 1'b1;
            first_idx = PW'(j);
            if (PW'(j) >= ptr) begin
               upper_vld = 1'b1;
               upper_idx = PW'(j);
            end
         end
      end
      grant_vld = (state == IDLE) && first_vld;
      grant_idx = upper_vld ? upper_idx : first_idx;
   end

   // Field mux for the granted port, plus the single combinational ready bit.
   always_comb begin
      sel_write   = 1'b0;
      sel_addr    = '0;
      sel_fn      = '0;
      sel_wdata   = '0;
      sel_be      = '0;
      s_req_ready = '0;
      for (int unsigned j = 0; j < PORTS; j++) begin
         if (grant_idx == PW'(j)) begin
            sel_write      = s_req_write[j];
            sel_addr       = s_req_addr[j*10 +: 10];
            sel_fn         = s_req_function_number[j*8 +: 8];
            sel_wdata      = s_req_write_data[j*32 +: 32];
            sel_be         = s_req_byte_enable[j*4 +: 4];
            s_req_ready[j] = grant_vld;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; done has priority over a coinciding timeout.
   always_comb begin
      state_nxt    = state;
      done_exit    = 1'b0;
      timeout_exit = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cfg_mgmt_read_write_done) begin
               done_exit = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               timeout_exit = 1'b1;
               state_nxt    = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == ACTIVE);

   // Request latch, strobes, timeout counter and response generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr                      <= '0;
         owner                    <= '0;
         cnt                      <= '0;
         cfg_mgmt_addr            <= '0;
         cfg_mgmt_function_number <= '0;
         cfg_mgmt_write           <= 1'b0;
         cfg_mgmt_write_data      <= '0;
         cfg_mgmt_byte_enable     <= '0;
         cfg_mgmt_read            <= 1'b0;
         s_resp_valid             <= '0;
         s_resp_read_data         <= '0;
         s_resp_error             <= 1'b0;
      end else begin
         s_resp_valid <= '0;
         if (grant_vld) begin
            owner                    <= grant_idx;
            ptr                      <= (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + PW'(1);
            cnt                      <= '0;
            cfg_mgmt_addr            <= sel_addr;
            cfg_mgmt_function_number <= sel_fn;
            cfg_mgmt_write_data      <= sel_wdata;
            cfg_mgmt_byte_enable     <= sel_write ? sel_be : 4'h0;
            cfg_mgmt_write           <= sel_write;
            cfg_mgmt_read            <= !sel_write;
         end else if (state == ACTIVE) begin
            cnt <= cnt + CW'(1);
            if (done_exit || timeout_exit) begin
               cfg_mgmt_write   <= 1'b0;
               cfg_mgmt_read    <= 1'b0;
               s_resp_error     <= timeout_exit;
               s_resp_read_data <= done_exit ? cfg_mgmt_read_data : 32'hFFFF_FFFF;
               for (int unsigned j = 0; j < PORTS; j++) begin
                  if (owner == PW'(j)) begin
                     s_resp_valid[j] <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_arb.sv
// Directed bench for pcie_us_cfg_mgmt_arb: table of back-to-back transactions
// plus hand-written sequences for done-while-idle and mid-transaction reset.
module tb_pcie_us_cfg_mgmt_arb;

   localparam int unsigned PORTS   = 4;
   localparam int unsigned TIMEOUT = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [PORTS-1:0]    s_req_valid;
   logic [PORTS-1:0]    s_req_ready;
   logic [PORTS-1:0]    s_req_write;
   logic [PORTS*10-1:0] s_req_addr;
   logic [PORTS*8-1:0]  s_req_function_number;
   logic [PORTS*32-1:0] s_req_write_data;
   logic [PORTS*4-1:0]  s_req_byte_enable;
   logic [PORTS-1:0]    s_resp_valid;
   logic [31:0]         s_resp_read_data;
   logic                s_resp_error;
   logic [9:0]          cfg_mgmt_addr;
   logic [7:0]          cfg_mgmt_function_number;
   logic                cfg_mgmt_write;
   logic [31:0]         cfg_mgmt_write_data;
   logic [3:0]          cfg_mgmt_byte_enable;
   logic                cfg_mgmt_read;
   logic [31:0]         cfg_mgmt_read_data;
   logic                cfg_mgmt_read_write_done;
   logic                busy;

   always #5 clk = ~clk;

   pcie_us_cfg_mgmt_arb #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .s_req_valid              (s_req_valid),
      .s_req_ready              (s_req_ready),
      .s_req_write              (s_req_write),
      .s_req_addr               (s_req_addr),
      .s_req_function_number    (s_req_function_number),
      .s_req_write_data         (s_req_write_data),
      .s_req_byte_enable        (s_req_byte_enable),
      .s_resp_valid             (s_resp_valid),
      .s_resp_read_data         (s_resp_read_data),
      .s_resp_error             (s_resp_error),
      .cfg_mgmt_addr            (cfg_mgmt_addr),
      .cfg_mgmt_function_number (cfg_mgmt_function_number),
      .cfg_mgmt_write           (cfg_mgmt_write),
      .cfg_mgmt_write_data      (cfg_mgmt_write_data),
      .cfg_mgmt_byte_enable     (cfg_mgmt_byte_enable),
      .cfg_mgmt_read            (cfg_mgmt_read),
      .cfg_mgmt_read_data       (cfg_mgmt_read_data),
      .cfg_mgmt_read_write_done (cfg_mgmt_read_write_done),
      .busy                     (busy)
   );

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  wr;
      int          done_cyc;   // strobe cycle carrying done; 0 = never (timeout)
      logic [31:0] rdata;
      logic [3:0]  gnt;
      logic        err;
      logic [31:0] data;
   } vec_t;

   localparam int NVEC = 12;
   vec_t tbl [NVEC];

   logic [9:0]  p_addr  [PORTS];
   logic [7:0]  p_fn    [PORTS];
   logic [31:0] p_wdata [PORTS];
   logic [3:0]  p_be    [PORTS];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_resp(input vec_t v);
      logic is_wr;
      is_wr = |(v.gnt & v.wr);
      check("resp_valid", 32'(s_resp_valid), 32'(v.gnt));
      check("resp_error", 32'(s_resp_error), 32'(v.err));
      if (!is_wr) check("resp_data", s_resp_read_data, v.data);
      check("strobe_low_rd", 32'(cfg_mgmt_read), 32'h0);
      check("strobe_low_wr", 32'(cfg_mgmt_write), 32'h0);
      check("busy_idle", 32'(busy), 32'h0);
   endtask

   initial begin
      p_addr[0] = 10'h010; p_fn[0] = 8'h01; p_wdata[0] = 32'hDEAD_BEEF; p_be[0] = 4'hF;
      p_addr[1] = 10'h020; p_fn[1] = 8'h02; p_wdata[1] = 32'h1111_0001; p_be[1] = 4'h3;
      p_addr[2] = 10'h004; p_fn[2] = 8'h03; p_wdata[2] = 32'h1111_0002; p_be[2] = 4'h5;
      p_addr[3] = 10'h030; p_fn[3] = 8'h04; p_wdata[3] = 32'h1111_0003; p_be[3] = 4'hC;
      for (int p = 0; p < PORTS; p++) begin
         s_req_addr[p*10 +: 10]           = p_addr[p];
         s_req_function_number[p*8 +: 8]  = p_fn[p];
         s_req_write_data[p*32 +: 32]     = p_wdata[p];
         s_req_byte_enable[p*4 +: 4]      = p_be[p];
      end

      //           valid wr   done rdata          gnt  err data
      tbl[0]  = '{4'hF, 4'h1, 1, 32'h0000_1000, 4'h1, 1'b0, 32'h0};
      tbl[1]  = '{4'hF, 4'h1, 1, 32'h0000_1001, 4'h2, 1'b0, 32'h0000_1001};
      tbl[2]  = '{4'hF, 4'h1, 1, 32'h0000_1002, 4'h4, 1'b0, 32'h0000_1002};
      tbl[3]  = '{4'hF, 4'h1, 1, 32'h0000_1003, 4'h8, 1'b0, 32'h0000_1003};
      tbl[4]  = '{4'hF, 4'h1, 1, 32'h0000_1004, 4'h1, 1'b0, 32'h0};
      tbl[5]  = '{4'hE, 4'h1, 2, 32'h2222_0001, 4'h2, 1'b0, 32'h2222_0001};
      tbl[6]  = '{4'hC, 4'h1, 3, 32'h1234_5678, 4'h4, 1'b0, 32'h1234_5678};
      tbl[7]  = '{4'h8, 4'h1, 1, 32'h3333_0003, 4'h8, 1'b0, 32'h3333_0003};
      tbl[8]  = '{4'h1, 4'h1, 4, 32'h0BAD_0BAD, 4'h1, 1'b0, 32'h0};
      tbl[9]  = '{4'h2, 4'h0, 0, 32'h5555_5555, 4'h2, 1'b1, 32'hFFFF_FFFF};
      tbl[10] = '{4'hC, 4'h0, 8, 32'hA5A5_5A5A, 4'h4, 1'b0, 32'hA5A5_5A5A};
      tbl[11] = '{4'h8, 4'h8, 1, 32'h7777_7777, 4'h8, 1'b0, 32'h0};

      // Reset state
      rst_n = 1'b0;
      s_req_valid = '0;
      s_req_write = '0;
      cfg_mgmt_read_data = '0;
      cfg_mgmt_read_write_done = 1'b0;
      #12;
      check("rst_ready", 32'(s_req_ready), 32'h0);
      check("rst_read", 32'(cfg_mgmt_read), 32'h0);
      check("rst_write", 32'(cfg_mgmt_write), 32'h0);
      check("rst_resp_valid", 32'(s_resp_valid), 32'h0);
      check("rst_resp_data", s_resp_read_data, 32'h0);
      check("rst_resp_error", 32'(s_resp_error), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back transactions; each grant lands in the previous response cycle
      for (int i = 0; i < NVEC; i++) begin
         int   g;
         logic wr_exp;
         logic got_done;
         s_req_valid = tbl[i].valid;
         s_req_write = tbl[i].wr;
         #4;
         if (i > 0) check_resp(tbl[i-1]);
         check("ready", 32'(s_req_ready), 32'(tbl[i].gnt));
         g = 0;
         for (int p = 0; p < PORTS; p++) if (tbl[i].gnt[p]) g = p;
         wr_exp = tbl[i].wr[g];
         got_done = 1'b0;
         @(posedge clk); #1;
         for (int c = 1; c <= int'(TIMEOUT); c++) begin
            cfg_mgmt_read_data = tbl[i].rdata;
            #4;
            check("strobe_rd", 32'(cfg_mgmt_read), 32'(!wr_exp));
            check("strobe_wr", 32'(cfg_mgmt_write), 32'(wr_exp));
            check("addr", 32'(cfg_mgmt_addr), 32'(p_addr[g]));
            check("fn", 32'(cfg_mgmt_function_number), 32'(p_fn[g]));
            check("be", 32'(cfg_mgmt_byte_enable), wr_exp ? 32'(p_be[g]) : 32'h0);
            if (wr_exp) check("wdata", cfg_mgmt_write_data, p_wdata[g]);
            check("busy_active", 32'(busy), 32'h1);
            check("no_resp_active", 32'(s_resp_valid), 32'h0);
            check("no_ready_active", 32'(s_req_ready), 32'h0);
            if (c == tbl[i].done_cyc) cfg_mgmt_read_write_done = 1'b1;
            @(posedge clk); #1;
            if (cfg_mgmt_read_write_done) begin
               cfg_mgmt_read_write_done = 1'b0;
               got_done = 1'b1;
            end
            cfg_mgmt_read_data = 32'h5A5A_0000;
            if (got_done) break;
         end
      end
      s_req_valid = '0;
      s_req_write = '0;
      #4;
      check_resp(tbl[NVEC-1]);
      check("ready_none", 32'(s_req_ready), 32'h0);

      // Done while idle is ignored
      cfg_mgmt_read_write_done = 1'b1;
      @(posedge clk); #1;
      cfg_mgmt_read_write_done = 1'b0;
      #4;
      check("idle_done_resp", 32'(s_resp_valid), 32'h0);
      check("idle_done_busy", 32'(busy), 32'h0);
      check("idle_done_rd", 32'(cfg_mgmt_read), 32'h0);

      // Reset mid-transaction: strobes drop at once, no response, priority back to port 0
      s_req_valid = 4'h2;
      @(posedge clk); #1;
      s_req_valid = '0;
      @(posedge clk); #1;
      check("pre_rst_rd", 32'(cfg_mgmt_read), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rd", 32'(cfg_mgmt_read), 32'h0);
      check("mid_rst_wr", 32'(cfg_mgmt_write), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
      check("mid_rst_resp", 32'(s_resp_valid), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      s_req_valid = 4'hF;
      #3;
      check("post_rst_prio", 32'(s_req_ready), 32'h1);
      @(posedge clk); #1;
      s_req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pcie_us_cfg_mgmt_arb.md
Name: pcie_us_cfg_mgmt_arb

Overview:
Round-robin arbiter that shares the single UltraScale+ PCIe hard-IP configuration management port among PORTS requesters (e.g. host-visible config shadow, MSI setup, debug access). Each request is latched, issued as one read or write strobe held until cfg_mgmt_read_write_done, and answered with exactly one response pulse to the originating requester. A timeout prevents a missing done from locking the port. Sits between core-side control logic and the hard IP cfg_mgmt_* pins, in the PCIe user clock domain.

Parameters:
PORTS, 4, number of requesters (1..16)
TIMEOUT, 1023, max cycles in ACTIVE without done before abort (>=2); counter width $clog2(TIMEOUT+1)

Ports:
clk  input  1  PCIe user clock
rst_n  input  1  asynchronous active-low reset
s_req_valid  input  PORTS  per-port request valid; held with fields until s_req_ready
s_req_ready  output  PORTS  per-port accept, one-hot or zero
s_req_write  input  PORTS  1=write, 0=read
s_req_addr  input  PORTS*10  config dword address
s_req_function_number  input  PORTS*8  function number
s_req_write_data  input  PORTS*32  write data
s_req_byte_enable  input  PORTS*4  write byte enables
s_resp_valid  output  PORTS  one-cycle response pulse to the originating port
s_resp_read_data  output  32  read data (shared, qualified by s_resp_valid)
s_resp_error  output  1  1 = timed out (shared, qualified)
cfg_mgmt_addr  output  10  to hard IP
cfg_mgmt_function_number  output  8  to hard IP
cfg_mgmt_write  output  1  write strobe
cfg_mgmt_write_data  output  32  to hard IP
cfg_mgmt_byte_enable  output  4  to hard IP
cfg_mgmt_read  output  1  read strobe
cfg_mgmt_read_data  input  32  from hard IP
cfg_mgmt_read_write_done  input  1  completion pulse from hard IP
busy  output  1  1 while in ACTIVE

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state IDLE, all outputs 0, s_resp_read_data 0, round-robin pointer at port 0 (highest priority), timeout counter 0. Reset mid-transaction aborts silently: no response pulse, strobes drop immediately.
- States: IDLE, ACTIVE.
- IDLE: grant = first asserted s_req_valid starting at pointer, wrapping modulo PORTS. s_req_ready[grant] is combinational, high that cycle only; no other ready bit high. On grant, latch write, addr, function, data, byte enable (byte enable forced to 0 on read); pointer <= grant+1 mod PORTS; go to ACTIVE. No valid requests: stay IDLE, outputs hold 0 strobes.
- ACTIVE: cfg_mgmt_write = latched write, cfg_mgmt_read = !latched write, exactly one high; all cfg_mgmt_* fields stable for the whole state. The counter increments each cycle.
- Done sampled in ACTIVE: next cycle strobes 0, state IDLE, s_resp_valid[grant]=1 for one cycle, s_resp_error=0, s_resp_read_data = cfg_mgmt_read_data captured on done (for writes, the captured value is unspecified; requesters ignore it).
- Counter reaching TIMEOUT without done: same exit, s_resp_error=1, s_resp_read_data=32'hFFFFFFFF. Done and timeout in the same cycle: done wins, error=0.
- Done while IDLE: ignored.
- Latency: request accepted cycle 0 -> strobe high cycle 1 -> done at cycle k -> response and strobe low at k+1. New grant possible at k+1, strobe re-asserted at k+2. This guarantees at least one deasserted cycle between transactions.
- A request accepted in the IDLE cycle that coincides with a response is legal; that response belongs to the previous grant.
- Fairness: every continuously valid port is served within PORTS transactions.
- Requesters must not drop s_req_valid before ready. Behaviour if they do is undefined; no check is performed.

Test Plan:
- Single read: port 2 reads addr 0x004, done 3 cycles after the strobe with data 0x12345678 -> cfg_mgmt_read high for exactly 3 cycles with addr 0x004. s_resp_valid=4'b0100 one cycle later, read_data 0x12345678, error 0.
- Write: port 0 writes 0xDEADBEEF with BE 0xF to addr 0x010 -> cfg_mgmt_write high, fields stable until done, then one response with error 0. cfg_mgmt_read never asserted.
- Contention: all 4 ports valid continuously, done after 1 cycle -> grant order 0,1,2,3,0. Each strobe is separated by exactly one low cycle.
- Timeout: TIMEOUT=8 and done never asserted -> strobe drops after 8 cycles. Response carries error 1 and data 0xFFFFFFFF, after which the next port is granted.
- Done and timeout coincide at cycle TIMEOUT -> error 0 and data taken from cfg_mgmt_read_data.
- Assert rst_n low mid-ACTIVE -> cfg_mgmt_read/write go to 0 immediately with no s_resp_valid. After release, port 0 has top priority again.
